// File: rtl/div_seq.sv
// Multi-cycle restoring divider (one quotient bit per cycle) with signed/unsigned mode and start/busy/done handshake.
// Optional signed-overflow flag output enabled by defining DIV_SEQ_OVF_FLAG_EN.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
`ifdef DIV_SEQ_OVF_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [CW-1:0]    cnt;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quot_nx;

  always_comb begin
    a_neg   = is_signed & dividend[WIDTH-1];
    b_neg   = is_signed & divisor[WIDTH-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    rem_sh  = {rem, num[cnt]};
    ge      = (rem_sh >= {1'b0, den});
    rem_nx  = ge ? WIDTH'(rem_sh - {1'b0, den}) : rem_sh[WIDTH-1:0];
    quot_nx = quot;
    quot_nx[cnt] = ge;
  end

`ifdef DIV_SEQ_OVF_FLAG_EN
  logic ovf_pend;
  logic ovf_now;

  always_comb begin
    ovf_now = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  end
`endif

  // Results are loaded on the edge entering FINISH so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      num      <= '0;
      den      <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
`ifdef DIV_SEQ_OVF_FLAG_EN
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            num   <= a_mag;
            den   <= b_mag;
            rem   <= '0;
            quot  <= '0;
            cnt   <= CW'(WIDTH - 1);
`ifdef DIV_SEQ_OVF_FLAG_EN
            ovf_pend <= ovf_now;
`endif
            if (divisor == '0) begin
              lo       <= '1;
              hi       <= dividend;
              div_zero <= 1'b1;
`ifdef DIV_SEQ_OVF_FLAG_EN
              overflow <= 1'b0;
`endif
              state    <= FINISH;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            lo       <= neg_q ? -quot_nx : quot_nx;
            hi       <= neg_r ? -rem_nx : rem_nx;
            div_zero <= 1'b0;
`ifdef DIV_SEQ_OVF_FLAG_EN
            overflow <= ovf_pend;
`endif
            state    <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FINISH);

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Parametrised multi-cycle restoring divider, one quotient bit per cycle.
- Successor to the fixed 32-bit HI/LO divider.
- Adds a WIDTH parameter, per-operation signed/unsigned mode, a start/busy/done handshake and a defined divide-by-zero result.
- Sits beside the ALU/multiplier and feeds the HI/LO register writeback for DIV/DIVU.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; accepted only while busy=0
- is_signed  input  1  1=two's-complement (DIV), 0=unsigned (DIVU); sampled with start
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  high while an accepted operation is in progress
- done  output  1  single-cycle pulse; results valid from this cycle on
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient
- div_zero  output  1  divisor was zero for the last completed operation

Behaviour:
- Reset (synchronous, takes effect at the clock edge where reset=1):
  - state=IDLE
  - busy=0, done=0, hi=0, lo=0, div_zero=0
  - all internal registers cleared
  - reset overrides start in the same cycle
  - reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, FINISH.
- IDLE:
  - Edge with start=1: latch is_signed, sign flags, |dividend|, |divisor| and the bit counter.
  - Magnitudes are taken only when is_signed=1 and the MSB is set.
  - If divisor==0, go to FINISH with div_zero pending; otherwise go to RUN with counter=WIDTH-1.
  - busy=1 from the cycle after acceptance.
- RUN, each cycle:
  - rem = {rem[WIDTH-2:0], num[counter]}
  - If rem >= den (unsigned, WIDTH+1-bit compare), subtract and set quot[counter]=1.
  - Leave for FINISH after the counter==0 cycle.
  - Exactly WIDTH RUN cycles.
- FINISH, one cycle, registering the outputs:
  - Normal: lo = quot, negated if signed and the operand signs differ. hi = rem, negated if signed and the dividend was negative.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide-by-zero: lo = all ones, hi = dividend as latched (original value, not magnitude), div_zero=1.
  - Signed MIN / -1: gives lo=MIN, hi=0 by natural wrap; no special handling.
  - done=1 for exactly this one cycle; busy=0 in this cycle; next state IDLE.
- Latency from the accept edge at T:
  - Normal operation: done is high during cycle T+WIDTH+1 (33 cycles for WIDTH=32).
  - Divide-by-zero: done is high during cycle T+1.
- Holding rules:
  - hi/lo/div_zero hold their values until the next FINISH or reset.
  - div_zero is never cleared by start alone.
- start while busy=1 is ignored: no queueing and no operand resampling.
- start during the FINISH cycle is ignored; start may be accepted in the cycle after done.
- Operands may change freely after the accept edge.
- Zero quotient or remainder is never negated (negating 0 yields 0 by arithmetic anyway).

Optional Feature:
- Macro: DIV_SEQ_OVF_FLAG_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0.
  - overflow is set in FINISH when is_signed=1, dividend=MIN and divisor=all ones; otherwise cleared in FINISH.
  - Held like div_zero.
  - Result values are unchanged (lo=MIN, hi=0).
- Not defined: port is absent; no detection logic; behaviour otherwise identical.

Test Plan:
1. WIDTH=32, is_signed=1, dividend=-7, divisor=2, start pulse at T -> busy from T+1, done only at T+33, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
2. is_signed=0, dividend=0xFFFFFFFF, divisor=0x10 -> lo=0x0FFFFFFF, hi=0xF. Repeat with is_signed=1 -> lo=0, hi=0xFFFFFFFF.
3. Divide-by-zero: dividend=0x1234, divisor=0 -> done at T+1, lo=0xFFFFFFFF, hi=0x1234, div_zero=1. Next valid op 10/3 -> div_zero=0, lo=3, hi=1.
4. start held high and operands changed during RUN -> single done, result of the first operands only. New op accepted the cycle after done.
5. Reset asserted at cycle T+10 of an operation -> next cycle busy=0, hi=lo=0; no done pulse within 40 cycles.
6. With DIV_SEQ_OVF_FLAG_EN: signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, overflow=1. Then 6/3 -> overflow=0, lo=2. Rerun tests 1-4 with WIDTH=8 (e.g. -128/3 -> lo=0xD6, hi=0xFE).
